// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : servo_pkg                                                    |
// | Description : Shared types, constants and arithmetic helpers for the       |
// |               hobby-servo PWM generator.                                   |
// |               - state_t        : two-state run/idle machine encoding       |
// |               - POS_W          : width of a servo position (6 bits)        |
// |               - CENTER_POS     : neutral position loaded at reset          |
// |               - calc_width_us  : position -> pulse width in microseconds   |
// |               - slew_step      : rate-limited move of a position           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package servo_pkg;

   localparam int unsigned      POS_W      = 6;
   localparam logic [POS_W-1:0] CENTER_POS = 6'd32;

   // Pulse-width arithmetic is carried at 32 bits, comfortably above the
   // 16-bit floor needed so MIN_US + 63*STEP_US never wraps for sane values.
   localparam int unsigned      WIDTH_W    = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Pulse width, in microseconds, that a given position maps onto.
   function automatic logic [WIDTH_W-1:0] calc_width_us(
      input logic [POS_W-1:0] pos,
      input int unsigned      min_us,
      input int unsigned      step_us
   );
      return WIDTH_W'(min_us) + (WIDTH_W'(pos) * WIDTH_W'(step_us));
   endfunction

   // Move cur toward tgt by at most slew units. slew is limited to 1..63 so
   // it always fits in a position-wide value.
   function automatic logic [POS_W-1:0] slew_step(
      input logic [POS_W-1:0] cur,
      input logic [POS_W-1:0] tgt,
      input int unsigned      slew
   );
      logic [POS_W-1:0] diff;
      logic [POS_W-1:0] lim;
      logic [POS_W-1:0] mv;
      lim = POS_W'(slew);
      if (tgt >= cur) begin
         diff = tgt - cur;
         mv   = (diff > lim) ? lim : diff;
         return cur + mv;
      end
      else begin
         diff = cur - tgt;
         mv   = (diff > lim) ? lim : diff;
         return cur - mv;
      end
   endfunction

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_tick_gen                                               |
// | Description : Free-running 1 us prescaler. Counts 0..TICK_DIV-1 and        |
// |               flags the terminal count on 'tick'.                          |
// | Ports       : clk_clk     in  system clock                                 |
// |               reset_reset in  synchronous active-high reset                |
// |               clear       in  hold the count at zero while high            |
// |               tick        out high during the terminal-count cycle         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module servo_tick_gen #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic clear,
   output logic tick
);

   // A divide-by-one prescaler still needs a one-bit register so the
   // terminal-count compare has something to look at; it simply stays at 0.
   localparam int unsigned      CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Combinational so the owning FSM sees the tick in the same cycle the
   // count reaches its end, keeping each microsecond exactly TICK_DIV cycles.
   assign tick = (r_cnt == C_TERMINAL);

   always_ff @(posedge clk_clk) begin
      if (reset_reset || clear) begin
         r_cnt <= '0;
      end
      else if (tick) begin
         r_cnt <= '0;
      end
      else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : servo_tick_gen
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_pwm_gen                                                |
// | Description : Hobby-servo PWM generator. Emits one pulse per FRAME_US      |
// |               frame whose width is MIN_US + cur_pos*STEP_US microseconds.  |
// |               The target position is sampled once per frame and the       |
// |               driven position walks toward it at most SLEW units/frame.    |
// | Ports       : clk_clk     in  system clock                                 |
// |               reset_reset in  synchronous active-high reset                |
// |               pos_in[5:0] in  requested position                           |
// |               enable      in  run the PWM while high                       |
// |               pwm_out     out servo control pulse (registered)             |
// |               frame_start out one-cycle strobe on frame cycle 0 (reg)      |
// |               cur_pos[5:0]out position being driven this frame (reg)      |
// |               busy        out cur_pos has not yet reached the target      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TICK_DIV = CLK_HZ / 1_000_000,
   parameter int unsigned FRAME_US = 20000,
   parameter int unsigned MIN_US   = 1000,
   parameter int unsigned STEP_US  = 16,
   parameter int unsigned SLEW     = 1
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [POS_W-1:0] pos_in,
   input  logic             enable,
   output logic             pwm_out,
   output logic             frame_start,
   output logic [POS_W-1:0] cur_pos,
   output logic             busy
);

   localparam int unsigned      US_W      = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam logic [US_W-1:0]  C_US_LAST = US_W'(FRAME_US - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t             r_state;
   logic [US_W-1:0]    r_us_cnt;
   logic [POS_W-1:0]   r_target;
   logic [POS_W-1:0]   r_cur_pos;
   logic               r_pwm;
   logic               r_frame_start;

   // ------------------------------------------------------------------------
   // Microsecond prescaler
   // ------------------------------------------------------------------------
   logic w_tick;
   logic w_clear;

   // Holding the prescaler clear whenever the machine is idle or about to
   // go idle guarantees the first RUN cycle always starts at count 0.
   assign w_clear = (r_state != RUN) || !enable;

   servo_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .clear       (w_clear),
      .tick        (w_tick)
   );

   // ------------------------------------------------------------------------
   // Next-cycle values
   // ------------------------------------------------------------------------
   logic                 w_frame_wrap;
   logic                 w_frame_begin;
   logic [US_W-1:0]      w_us_next;
   logic [POS_W-1:0]     w_next_pos;
   logic [WIDTH_W-1:0]   w_next_width;
   logic [WIDTH_W-1:0]   w_cur_width;

   assign w_frame_wrap  = (r_state == RUN) && w_tick && (r_us_cnt == C_US_LAST);

   // A frame begins either on entry from IDLE or on the microsecond wrap.
   assign w_frame_begin = enable && ((r_state == IDLE) || w_frame_wrap);

   assign w_us_next     = w_tick ? (r_us_cnt + US_W'(1)) : r_us_cnt;

   // Position and width the next frame will use; the target is sampled from
   // pos_in at the same edge, so the step is computed against pos_in here.
   assign w_next_pos    = slew_step(r_cur_pos, pos_in, SLEW);
   assign w_next_width  = calc_width_us(w_next_pos, MIN_US, STEP_US);
   assign w_cur_width   = calc_width_us(r_cur_pos, MIN_US, STEP_US);

   // ------------------------------------------------------------------------
   // Control FSM and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state       <= IDLE;
         r_us_cnt      <= '0;
         r_target      <= CENTER_POS;
         r_cur_pos     <= CENTER_POS;
         r_pwm         <= 1'b0;
         r_frame_start <= 1'b0;
      end
      else if (!enable) begin
         // Dropping enable truncates any pulse in flight on the next cycle.
         r_state       <= IDLE;
         r_us_cnt      <= '0;
         r_pwm         <= 1'b0;
         r_frame_start <= 1'b0;
      end
      else if (w_frame_begin) begin
         // Frame cycle 0: latch the target, take one slew step and let the
         // new position govern this very frame.
         r_state       <= RUN;
         r_us_cnt      <= '0;
         r_target      <= pos_in;
         r_cur_pos     <= w_next_pos;
         r_pwm         <= (w_next_width != '0);
         r_frame_start <= 1'b1;
      end
      else begin
         // Mid-frame: only the microsecond counter moves; pos_in is ignored
         // until the next frame boundary.
         r_state       <= RUN;
         r_us_cnt      <= w_us_next;
         r_pwm         <= (WIDTH_W'(w_us_next) < w_cur_width);
         r_frame_start <= 1'b0;
      end
   end

   assign pwm_out     = r_pwm;
   assign frame_start = r_frame_start;
   assign cur_pos     = r_cur_pos;
   assign busy        = (r_cur_pos != r_target);

endmodule : servo_pwm_gen
`default_nettype wire

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 The block SHALL have parameter TICK_DIV, default CLK_HZ/1_000_000, clocks per 1 us tick (>=1).
REQ-003 The block SHALL have parameter FRAME_US, default 20000, PWM period in us.
REQ-004 The block SHALL have parameter MIN_US, default 1000, pulse width for position 0.
REQ-005 The block SHALL have parameter STEP_US, default 16, pulse-width increment per position unit.
REQ-006 The block SHALL have parameter SLEW, default 1, maximum position change per frame (1..63).
REQ-007 The block SHALL have port clk_clk, input, 1, the single clock.
REQ-008 The block SHALL have port reset_reset, input, 1, reset (synchronous, active-high).
REQ-009 The block SHALL have port pos_in, input, 6, target position from the servo PIO export.
REQ-010 The block SHALL have port enable, input, 1, run PWM when high.
REQ-011 The block SHALL have port pwm_out, output, 1, servo control pulse.
REQ-012 The block SHALL have port frame_start, output, 1, one-cycle pulse at first cycle of each frame.
REQ-013 The block SHALL have port cur_pos, output, 6, position currently being driven.
REQ-014 The block SHALL have port busy, output, 1, high while cur_pos != latched target.

Function
REQ-015 The block SHALL use FSM states IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0 (both sampled at the clock edge).
REQ-016 In IDLE: pwm_out=0, frame_start=0, us counter and prescaler held at 0, cur_pos held.
REQ-017 The first RUN cycle SHALL be frame cycle 0: frame_start=1, pwm_out=1, prescaler and us_cnt=0.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1, emitting a tick on terminal count; us_cnt SHALL increment per tick and wrap FRAME_US-1 -> 0.
REQ-019 frame_start SHALL pulse for exactly one cycle on every us_cnt wrap to 0 and on IDLE->RUN entry.
REQ-020 At each frame_start, target SHALL latch pos_in, and cur_pos SHALL step toward the latched target by min(SLEW, |target-cur_pos|); the new cur_pos governs that same frame.
REQ-021 width_us = MIN_US + cur_pos*STEP_US, computed unsigned with 16-bit minimum width; pwm_out=1 while us_cnt < width_us, else 0.
REQ-022 pos_in changes mid-frame SHALL NOT affect the current frame.
REQ-023 Clearing enable mid-frame SHALL force pwm_out=0 on the next cycle (truncated pulse allowed); re-enable SHALL start a fresh frame per REQ-017.
REQ-024 busy SHALL be combinational: (cur_pos != target).
REQ-025 With default parameters, position 63 SHALL give 2008 us and position 0 SHALL give 1000 us.

Reset
REQ-026 On reset_reset=1 at a clock edge: state=IDLE, pwm_out=0, frame_start=0, cur_pos=32, target=32, us_cnt=0, prescaler=0.
REQ-027 Reset asserted mid-frame SHALL take effect at that edge, overriding enable; the block SHALL resume per REQ-017 on the first edge after release with enable=1.

Structure
REQ-028 Package servo_pkg SHALL hold the state enum (IDLE, RUN), POS_W=6, CENTER_POS=32 and the width_us calculation helper.
REQ-029 The 1 us prescaler SHALL be sub-module servo_tick_gen (inputs clk_clk, reset_reset, clear; output tick).
REQ-030 All outputs except busy SHALL be registered.

Verification (bench: TICK_DIV=1, FRAME_US=100, MIN_US=10, STEP_US=1, SLEW=4)
REQ-031 Reset then enable=1, pos_in=32 -> frame_start every 100 cycles, pwm_out high for 42 cycles per frame, busy=0.
REQ-032 From cur_pos=32, pos_in=50 -> cur_pos 36,40,44,48,50 on successive frames, busy drops in the frame cur_pos reaches 50, high time 60 cycles.
REQ-033 pos_in changed 32->0 at frame cycle 5 -> current frame keeps 42-cycle pulse, next frame cur_pos=28 (38-cycle pulse).
REQ-034 enable dropped at frame cycle 20 -> pwm_out=0 from the next cycle, no frame_start; re-enable -> frame_start and pwm_out=1 in the first RUN cycle.
REQ-035 reset_reset pulsed at frame cycle 30 with cur_pos=50 -> cur_pos=32, pwm_out=0, new frame starts the cycle after release.
REQ-036 Defaults (TICK_DIV=50): pos_in=63, after slew settles -> pulse 100400 cycles high in a 1000000-cycle frame.
